// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I load/store initiator for a word-addressed data memory
module mem_access_unit #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] read_data
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t      state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;   // store data; replaced by the merged word for sub-word stores
    logic [31:0] rdata_q;   // extended load result, 0 for stores and errors
    logic        err_q;

    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Request validation on the raw inputs, only consumed in the accept cycle
    always_comb begin
        illegal      = req_write ? (req_funct3 > 3'b010)
                                 : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        misaligned   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        out_of_range = (req_addr >= ADDR_LIMIT);
        req_err      = illegal || misaligned || out_of_range;
    end

    // Lane extraction with sign/zero extension for loads
    always_comb begin
        byte_lane = read_data[{addr_q[1:0], 3'b000} +: 8];
        half_lane = addr_q[1] ? read_data[31:16] : read_data[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_ext = {24'h0, byte_lane};
            3'b101:  load_ext = {16'h0, half_lane};
            default: load_ext = read_data;
        endcase
    end

    // Read-modify-write merge: replace only the addressed byte/half lane
    always_comb begin
        merged = read_data;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Access sequencer: IDLE -> (RD) -> (WR) -> DONE -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= 32'h0;
                        err_q    <= req_err;
                        if (req_err) begin
                            state <= DONE;
                        end else if (req_write && req_funct3 == 3'b010) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (write_q) begin
                        wdata_q <= merged;
                        state   <= WR;
                    end else begin
                        rdata_q <= load_ext;
                        state   <= DONE;
                    end
                end
                WR: begin
                    state <= DONE;
                end
                DONE: begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = !reset && (state == IDLE);
    assign mem_read   = !reset && (state == RD);
    assign mem_write  = !reset && (state == WR);
    assign resp_valid = !reset && (state == DONE);
    assign resp_rdata = (!reset && state == DONE) ? rdata_q : 32'h0;
    assign resp_err   = !reset && (state == DONE) && err_q;
    assign address    = (!reset && (state == RD || state == WR)) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign write_data = (!reset && state == WR) ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;

    logic [31:0] mem [0:63];

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.MEM_BYTES(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    assign read_data = mem[address[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[address[7:2]] <= write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and follow it to its response
    task automatic run_req(input string tag, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                           input logic [31:0] exp_wd, input int exp_nrd, input int exp_nwr);
        int  lat = 0;
        int  nrd = 0;
        int  nwr = 0;
        logic got = 1'b0;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
        req_write  = ~w;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFC;
        req_wdata  = 32'hDEAD_DEAD;
        while (!got && lat < 8) begin
            lat++;
            if (mem_read)  nrd++;
            if (mem_write) nwr++;
            if (mem_read && mem_write) check({tag, "_rdwr_overlap"}, 32'd1, 32'd0);
            if (mem_read || mem_write) check({tag, "_address"}, address, {a[31:2], 2'b00});
            if (mem_write) check({tag, "_wdata"}, write_data, exp_wd);
            if (resp_valid) begin
                got = 1'b1;
                check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
                check({tag, "_rdata"}, resp_rdata, exp_rd);
                check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
            end else begin
                step();
            end
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_nread"}, 32'(nrd), 32'(exp_nrd));
        check({tag, "_nwrite"}, 32'(nwr), 32'(exp_nwr));
        step();
        check({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, "_idle_addr"}, address, 32'd0);
    endtask

    int acc [2];
    int rsp [2];
    int nacc;
    int nrsp;
    int nw;
    logic pend;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0101_0101 * 32'(i);
        mem[4]  = 32'h8899_AABB;
        mem[10] = 32'h5566_7788;
        mem[63] = 32'h0BAD_C0DE;

        reset      = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'h0;
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        reset     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_address", address, 32'd0);
        check("post_rst_wdata", write_data, 32'd0);
        check("post_rst_mem_write", 32'(mem_write), 32'd0);
        check("post_rst_resp", {resp_rdata[30:0], resp_valid}, 32'd0);
        step();

        // loads
        run_req("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h8899_AABB, 1'b0, 32'h0, 1, 0);
        run_req("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 2, 32'hFFFF_FF88, 1'b0, 32'h0, 1, 0);
        run_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 2, 32'h0000_0088, 1'b0, 32'h0, 1, 0);
        run_req("lh10",  1'b0, 3'b001, 32'h10, 32'h0, 2, 32'hFFFF_AABB, 1'b0, 32'h0, 1, 0);
        run_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 2, 32'h0000_8899, 1'b0, 32'h0, 1, 0);
        run_req("lb11",  1'b0, 3'b000, 32'h11, 32'h0, 2, 32'hFFFF_FFAA, 1'b0, 32'h0, 1, 0);
        run_req("lwfc",  1'b0, 3'b010, 32'hFC, 32'h0, 2, 32'h0BAD_C0DE, 1'b0, 32'h0, 1, 0);

        // sub-word store via read-modify-write, then readback
        run_req("sb11",  1'b1, 3'b000, 32'h11, 32'hABCD_EF5A, 3, 32'h0, 1'b0, 32'h8899_5ABB, 1, 1);
        check("sb11_mem", mem[4], 32'h8899_5ABB);
        run_req("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h8899_5ABB, 1'b0, 32'h0, 1, 0);

        // full-word store and halfword RMW on top of it
        run_req("sw20",  1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 2, 32'h0, 1'b0, 32'hCAFE_F00D, 0, 1);
        run_req("sh22",  1'b1, 3'b001, 32'h22, 32'h1234_BEEF, 3, 32'h0, 1'b0, 32'hBEEF_F00D, 1, 1);
        check("sh22_mem", mem[8], 32'hBEEF_F00D);

        // rejected requests never touch memory
        run_req("sh21",  1'b1, 3'b001, 32'h21, 32'h1111, 1, 32'h0, 1'b1, 32'h0, 0, 0);
        run_req("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'h0, 1'b1, 32'h0, 0, 0);
        run_req("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, 32'h0, 0, 0);
        run_req("lw12",  1'b0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 1'b1, 32'h0, 0, 0);
        run_req("st011", 1'b1, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, 32'h0, 0, 0);
        check("sh21_mem", mem[8], 32'hBEEF_F00D);

        // reset during the RD cycle of an SH cancels the write
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h2A;
        req_wdata  = 32'h0000_FFFF;
        step();
        req_valid = 1'b0;
        check("rmw_rst_rd", 32'(mem_read), 32'd1);
        reset = 1'b1;
        #1;
        check("rmw_rst_forced", {30'h0, mem_read, req_ready}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rmw_rst_ready", 32'(req_ready), 32'd1);
        nw = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_write) nw++;
            step();
        end
        check("rmw_rst_nwrite", 32'(nw), 32'd0);
        check("rmw_rst_mem", mem[10], 32'h5566_7788);

        // two SW with req_valid held high: second accept follows the first response
        nacc = 0;
        nrsp = 0;
        nw   = 0;
        pend = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h30;
        req_wdata  = 32'h1111_AAAA;
        for (int c = 0; c < 12; c++) begin
            if (pend) begin
                pend = 1'b0;
                if (nacc == 1) begin
                    req_addr  = 32'h34;
                    req_wdata = 32'h2222_BBBB;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (req_ready && req_valid && nacc < 2) begin
                acc[nacc] = c;
                nacc++;
                pend = 1'b1;
            end
            if (resp_valid && nrsp < 2) begin
                rsp[nrsp] = c;
                nrsp++;
            end
            if (mem_write) nw++;
            step();
        end
        req_valid = 1'b0;
        check("b2b_naccept", 32'(nacc), 32'd2);
        check("b2b_nresp", 32'(nrsp), 32'd2);
        check("b2b_nwrite", 32'(nw), 32'd2);
        check("b2b_second_accept", 32'(acc[1]), 32'(rsp[0] + 1));
        check("b2b_first_lat", 32'(rsp[0]), 32'(acc[0] + 2));
        check("b2b_mem0", mem[12], 32'h1111_AAAA);
        check("b2b_mem1", mem[13], 32'h2222_BBBB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the data-memory interface: accepts one load/store request at a time from the CPU execute stage and drives the word-addressed data memory's `address`/`write_data`/`mem_read`/`mem_write` pins. It handles RV32I sub-word accesses:

- Loads are byte-lane extracted and sign- or zero-extended.
- Sub-word stores use a read-modify-write sequence, because the memory only writes full words.
- Misaligned, out-of-range, and illegal-size requests are rejected without touching memory.

## Interface
- `MEM_BYTES`, default 256: memory size in bytes. Any request with `addr >= MEM_BYTES` is an error.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present. Sampled only while `req_ready`=1.
- `req_ready`  out  1  unit idle and able to accept a request.
- `req_write`  in  1  1=store, 0=load.
- `req_funct3`  in  3  RV32I funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data. Bits [7:0] for SB, [15:0] for SH.
- `resp_valid`  out  1  one-cycle pulse: request complete.
- `resp_rdata`  out  32  extended load data. Valid with `resp_valid`; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`: request rejected.
- `address`  out  32  to memory. Always word-aligned: `{addr[31:2],2'b00}`.
- `write_data`  out  32  to memory: merged store word.
- `mem_read`  out  1  to memory: read strobe.
- `mem_write`  out  1  to memory: write strobe.
- `read_data`  in  32  from memory. Combinational; valid in the same cycle as `mem_read`.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE (`req_ready`=1): on `req_valid`, latch `write`, `funct3`, `addr`, `wdata`, then check the request.
  - Error if any of:
    - funct3 is illegal (loads 011/110/111, stores anything above 010);
    - halfword access with `addr[0]`=1;
    - word access with `addr[1:0]`≠0;
    - `addr >= MEM_BYTES`.
  - Error → DONE with `err`=1.
  - Otherwise:
    - load → RD;
    - SW → WR;
    - SB/SH → RD.
- RD: assert `mem_read`=1 and drive `address`; register `read_data` at the edge.
  - Load → DONE with the extended result:
    - byte lane = `addr[1:0]`; half lane = `addr[1]`;
    - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - SB/SH → WR.
- WR: assert `mem_write`=1 for exactly one cycle, with `address` and `write_data` stable the whole cycle.
  - SW: `write_data` = `wdata`.
  - SB/SH: `write_data` = registered read word with only the selected byte/half lane replaced by `wdata[7:0]`/`wdata[15:0]`.
  - Then → DONE.
- DONE: `resp_valid`=1 for one cycle with `resp_rdata`/`resp_err`, then → IDLE.
- `mem_read` and `mem_write` are never high in the same cycle. Both are 0 in IDLE and DONE.
- `address` and `write_data` are 0 in IDLE.
- The latched request is immune to `req_*` changes after acceptance.

## Timing
- Accept cycle = cycle N, when IDLE and `req_valid`=1.
- `resp_valid` arrives at:
  - load: N+2 (RD at N+1);
  - SW: N+2 (WR at N+1);
  - SB/SH: N+3 (RD N+1, WR N+2);
  - error: N+1.
- `req_ready` is 1 in IDLE only. The earliest next accept is the cycle after DONE, so there is no back-to-back overlap.
- Reset: while `reset`=1, all outputs are combinationally forced to 0, including `mem_read`/`mem_write`/`req_ready`. State → IDLE at the edge, and all registers clear to 0.
  - Reset mid-RMW (in RD or WR) cancels the access; no partial write is issued after reset deasserts.
  - First cycle after reset: `req_ready`=1 and all other outputs 0.
- A `req_valid` held high while `reset`=1 is ignored.

## Test plan
- LW at 0x10, memory word 4 = 0x8899AABB → `mem_read` pulse at N+1 with `address`=0x10; `resp_valid` at N+2, `resp_rdata`=0x8899AABB, `err`=0.
- LB at 0x13 and LBU at 0x13 on the same word → `resp_rdata`=0xFFFFFF88 and 0x00000088 respectively. LH at 0x10 → 0xFFFFAABB.
- SB 0x5A at 0x11 over 0x8899AABB → `mem_read` at N+1, `mem_write` at N+2 with `write_data`=0x88995ABB, `resp_valid` at N+3. A readback LW returns 0x88995ABB.
- SH at 0x21 → `resp_valid`+`resp_err` at N+1, no `mem_read`/`mem_write` ever. The same result for LW at 0x100 (MEM_BYTES=256) and for load funct3=011.
- Reset asserted in the RD cycle of an SH → `mem_write` never pulses, the target word is unchanged, and `req_ready`=1 the cycle after reset drops.
- Two SW requests with `req_valid` held high continuously → the second is accepted only in the cycle after the first `resp_valid`, and two single `mem_write` pulses are observed.
